// File: rtl/dct_pkg.sv
// Shared definitions for the DCT coefficient collector: frame geometry,
// the read-side FSM encoding and the completed-frame mask value.
package dct_pkg;
    localparam int N     = 8;
    localparam int IDX_W = 3;
    localparam int OUT_W = 18;

    localparam logic [N-1:0] FRAME_MASK_FULL = 8'hFF;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_t;
endpackage

// File: rtl/dct_coeff_collector_if.sv
// Bundles the indexed coefficient input stream and the ordered valid/ready
// output stream of the collector, plus its error pulses.
interface dct_coeff_collector_if #(
    parameter int OUT_W = dct_pkg::OUT_W,
    parameter int IDX_W = dct_pkg::IDX_W
) ();
    logic [OUT_W-1:0] coeff_in;
    logic             valid_in;
    logic [IDX_W-1:0] index_in;
    logic [OUT_W-1:0] data_out;
    logic [IDX_W-1:0] idx_out;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             dup_err;
    logic             overflow;

    modport master (
        input  coeff_in, valid_in, index_in, out_ready,
        output data_out, idx_out, out_valid, out_last, dup_err, overflow
    );

    modport slave (
        output coeff_in, valid_in, index_in, out_ready,
        input  data_out, idx_out, out_valid, out_last, dup_err, overflow
    );
endinterface

// File: rtl/dct_frame_bank.sv
// One 8-entry coefficient bank with a written-index mask; flags a repeated
// index and the write that fills the last missing slot (mask then self-clears).
module dct_frame_bank
    import dct_pkg::*;
#(
    parameter int OUT_W = dct_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [OUT_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [OUT_W-1:0] rdata,
    output logic             dup,
    output logic             mask_full
);
    logic [OUT_W-1:0] mem [N];
    logic [N-1:0]     mask;
    logic [N-1:0]     mask_next;
    logic [N-1:0]     wbit;

    // Completion looks at the mask including this write, so a repeat never completes.
    always_comb begin
        wbit        = '0;
        wbit[waddr] = we;
        dup         = we & mask[waddr];
        mask_next   = mask | wbit;
        mask_full   = we & ~dup & (mask_next == FRAME_MASK_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else if (mask_full) begin
            mask <= '0;
        end else begin
            mask <= mask_next;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dct_coeff_collector.sv
// Assembles out-of-order DCT coefficients into ping-pong frame banks and
// replays each complete frame in index order 0..7 over valid/ready.
module dct_coeff_collector
    import dct_pkg::*;
#(
    parameter int OUT_W = dct_pkg::OUT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dct_coeff_collector_if.master bus
);
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic [IDX_W-1:0] rd_ptr;
    rd_state_t        state;

    logic [1:0]       we;
    logic [1:0]       dup;
    logic [1:0]       mfull;
    logic [OUT_W-1:0] rdata [2];
    logic             accept;
    logic             frame_done;
    logic [1:0]       set_vec;
    logic [1:0]       clr_vec;

    rd_state_t        state_next;
    logic [IDX_W-1:0] ptr_next;
    logic             bank_next;
    logic             load;
    logic             clear_out;
    logic             free_bank;
    logic             rd_sel;
    logic [IDX_W-1:0] rd_addr;
    logic             hs;

    logic [OUT_W-1:0] data_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             last_q;
    logic             dup_q;
    logic             ovf_q;

    // Write side: a full target bank drops the sample before anything else is looked at.
    assign accept     = bus.valid_in & ~full[wr_bank];
    assign we[0]      = accept & ~wr_bank;
    assign we[1]      = accept &  wr_bank;
    assign frame_done = mfull[wr_bank];
    assign set_vec    = frame_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign clr_vec    = free_bank  ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_frame_bank #(.OUT_W(OUT_W)) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .we        (we[b]),
            .waddr     (bus.index_in),
            .wdata     (bus.coeff_in),
            .raddr     (rd_addr),
            .rdata     (rdata[b]),
            .dup       (dup[b]),
            .mask_full (mfull[b])
        );
    end

    assign hs = valid_q & bus.out_ready;

    always_comb begin
        state_next = state;
        ptr_next   = rd_ptr;
        bank_next  = rd_bank;
        load       = 1'b0;
        clear_out  = 1'b0;
        free_bank  = 1'b0;
        rd_sel     = rd_bank;
        rd_addr    = rd_ptr;
        case (state)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    state_next = RD_DRAIN;
                    ptr_next   = '0;
                    rd_addr    = '0;
                    load       = 1'b1;
                end
            end
            RD_DRAIN: begin
                if (hs) begin
                    if (rd_ptr == IDX_W'(N - 1)) begin
                        free_bank = 1'b1;
                        bank_next = ~rd_bank;
                        ptr_next  = '0;
                        rd_addr   = '0;
                        rd_sel    = ~rd_bank;
                        // Other bank already waiting: continue without a bubble.
                        if (full[~rd_bank]) begin
                            load = 1'b1;
                        end else begin
                            state_next = RD_IDLE;
                            clear_out  = 1'b1;
                        end
                    end else begin
                        ptr_next = rd_ptr + 1'b1;
                        rd_addr  = rd_ptr + 1'b1;
                        load     = 1'b1;
                    end
                end
            end
            default: state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RD_IDLE;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            rd_ptr  <= '0;
            full    <= '0;
            dup_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_next;
            rd_ptr  <= ptr_next;
            rd_bank <= bank_next;
            full    <= (full | set_vec) & ~clr_vec;
            if (frame_done) begin
                wr_bank <= ~wr_bank;
            end
            dup_q   <= |dup;
            ovf_q   <= bus.valid_in & full[wr_bank];
        end
    end

    // Output register stage: holds its value while stalled, zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load) begin
            data_q  <= rd_sel ? rdata[1] : rdata[0];
            idx_q   <= rd_addr;
            valid_q <= 1'b1;
            last_q  <= (rd_addr == IDX_W'(N - 1));
        end else if (clear_out) begin
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.idx_out   = idx_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.dup_err   = dup_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_dct_coeff_collector.sv
// Scoreboard bench for dct_coeff_collector: frames are modelled as they are
// written and expected elements are popped on every output handshake.
module tb_dct_coeff_collector;
    import dct_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dct_coeff_collector_if bus ();

    dct_coeff_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [OUT_W-1:0] data;
        logic             last;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               failures = 0;
    logic [7:0]       mdl_mask;
    logic [OUT_W-1:0] mdl_data [8];
    int               dup_exp = 0;
    int               ovf_exp = 0;
    int               dup_cnt = 0;
    int               ovf_cnt = 0;
    int               cyc = 0;
    int               first_hs = -1;
    int               last_hs = -1;
    bit               rand_mode = 0;
    bit               prev_stall = 0;
    logic [OUT_W-1:0] prev_data;
    logic [IDX_W-1:0] prev_idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: stall stability, idle zeroing, pulse counting and scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_data", 32'(bus.data_out), 32'(prev_data));
                chk("stall_idx", 32'(bus.idx_out), 32'(prev_idx));
            end
            if (!bus.out_valid) chk("idle_zero", 32'(bus.data_out), 32'd0);
            if (bus.dup_err) dup_cnt++;
            if (bus.overflow) ovf_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 32'(bus.data_out), 32'(e.data));
                    chk("idx", 32'(bus.idx_out), 32'(e.idx));
                    chk("last", 32'(bus.out_last), 32'(e.last));
                end
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            prev_stall = bus.out_valid & ~bus.out_ready;
            prev_data  = bus.data_out;
            prev_idx   = bus.idx_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int idx, input logic [OUT_W-1:0] val, input bit drop);
        bus.valid_in = 1'b1;
        bus.index_in = IDX_W'(idx);
        bus.coeff_in = val;
        tick();
        bus.valid_in = 1'b0;
        if (drop) begin
            ovf_exp++;
        end else begin
            if (mdl_mask[idx]) dup_exp++;
            mdl_mask[idx] = 1'b1;
            mdl_data[idx] = val;
            if (mdl_mask == 8'hFF) begin
                for (int i = 0; i < 8; i++) begin
                    exp_q.push_back('{idx: IDX_W'(i), data: mdl_data[i], last: (i == 7)});
                end
                mdl_mask = '0;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic wait_room(input int budget);
        int n = 0;
        while (exp_q.size() > 8 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() > 8) chk("room_timeout", 32'(exp_q.size()), 32'd8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_idx", 32'(bus.idx_out), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_dup", 32'(bus.dup_err), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        exp_q.delete();
        mdl_mask = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int perm [8];
        int j;
        int t;
        bus.valid_in  = 1'b0;
        bus.index_in  = '0;
        bus.coeff_in  = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;
        mdl_mask      = '0;
        #2;
        do_reset();

        // In-order frame with first-output latency check.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(i, OUT_W'((i + 1) * 10), 0);
        @(negedge clk);
        chk("lat_t", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("lat_t1", 32'(bus.out_valid), 32'd1);
        wait_drain(50);

        // Reverse order.
        for (int i = 0; i < 8; i++) send(7 - i, OUT_W'(7 - i), 0);
        wait_drain(50);
        chk("t2_dup", 32'(dup_cnt), 32'(dup_exp));
        chk("t2_ovf", 32'(ovf_cnt), 32'(ovf_exp));

        // Duplicate index 3.
        send(3, 5, 0);
        send(3, 9, 0);
        for (int i = 0; i < 8; i++) if (i != 3) send(i, OUT_W'(100 + i), 0);
        wait_drain(50);
        chk("t3_dup", 32'(dup_cnt), 32'd1);

        // Both banks held, third frame dropped, then no-bubble release.
        bus.out_ready = 1'b0;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 8; i++) send(i, OUT_W'(1000 + f * 8 + i), f == 2);
        repeat (3) tick();
        chk("t4_ovf", 32'(ovf_cnt), 32'd8);
        chk("t4_hold", 32'(bus.out_valid), 32'd1);
        first_hs = -1;
        bus.out_ready = 1'b1;
        wait_drain(60);
        chk("t4_nobubble", 32'(last_hs - first_hs), 32'd15);

        // Random stalls, random index order and data.
        rand_mode = 1;
        for (int f = 0; f < 4; f++) begin
            wait_room(200);
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
            for (int i = 0; i < 8; i++) send(perm[i], OUT_W'($urandom), 0);
        end
        wait_drain(400);
        rand_mode = 0;
        bus.out_ready = 1'b1;
        chk("t5_dup", 32'(dup_cnt), 32'(dup_exp));
        chk("t5_ovf", 32'(ovf_cnt), 32'(ovf_exp));

        // Reset mid-frame, then reset during a drain.
        for (int i = 0; i < 4; i++) send(i, OUT_W'(500 + i), 0);
        do_reset();
        for (int i = 0; i < 8; i++) send(i, OUT_W'(600 + i), 0);
        wait_drain(50);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(i, OUT_W'(700 + i), 0);
        repeat (3) tick();
        chk("t6_drain", 32'(bus.out_valid), 32'd1);
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(7 - i, OUT_W'(800 + i), 0);
        wait_drain(50);
        chk("t6_dup", 32'(dup_cnt), 32'(dup_exp));
        chk("t6_ovf", 32'(ovf_cnt), 32'(ovf_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
